// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl: sequences a shared 1-bit comparator over two WIDTH-bit
// operands, MSB first, one bit per clock, and reports a gt/eq/lt result.
// A comparator response that is not one-hot aborts the compare.
// That abort also sets a sticky error flag, which only reset clears.
module serial_cmp_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             err
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx;
  logic             dec_gt;
  logic             dec_lt;

  logic [1:0]       resp_cnt;
  logic             run_abort;
  logic             run_early;
  logic             run_end;
  logic             decided;
  logic             res_gt;
  logic             res_lt;
  logic             res_eq;
  logic [IW-1:0]    idx_nxt;

  // Decode the comparator response for the bit currently on cmp_a/cmp_b.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    resp_cnt  = '0;
    run_abort = 1'b0;
    run_early = 1'b0;
    run_end   = 1'b0;
    decided   = 1'b0;
    res_gt    = 1'b0;
    res_lt    = 1'b0;
    res_eq    = 1'b0;
    idx_nxt   = idx - IW'(1);

    resp_cnt  = {1'b0, cmp_gt} + {1'b0, cmp_eq} + {1'b0, cmp_lt};
    run_abort = (resp_cnt != 2'd1);
    run_early = EARLY_EXIT && (cmp_gt || cmp_lt);
    run_end   = run_abort || run_early || (idx == '0);
    decided   = dec_gt || dec_lt;

    // An earlier differing bit wins. Otherwise the current bit decides,
    // and with no difference at all the result is equal.
    if (run_abort) begin
      res_gt = 1'b0;
      res_lt = 1'b0;
      res_eq = 1'b0;
    end else begin
      res_gt = decided ? dec_gt : cmp_gt;
      res_lt = decided ? dec_lt : cmp_lt;
      res_eq = !(res_gt || res_lt);
    end
  end

  // Control FSM with registered outputs; operands and results live here too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the operand registers are reset as well, so a
      // post-reset state never exposes stale operand data.
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      idx    <= '0;
      dec_gt <= 1'b0;
      dec_lt <= 1'b0;
      cmp_a  <= 1'b0;
      cmp_b  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      gt     <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only: every register in this block
      // updates from pre-edge values, whatever the statement order.
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg  <= a_in;
            b_reg  <= b_in;
            idx    <= IW'(WIDTH - 1);
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
            cmp_a  <= a_in[WIDTH-1];
            cmp_b  <= b_in[WIDTH-1];
            gt     <= 1'b0;
            eq     <= 1'b0;
            lt     <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end

        RUN: begin
          if (run_end) begin
            gt    <= res_gt;
            eq    <= res_eq;
            lt    <= res_lt;
            err   <= err || run_abort;
            cmp_a <= 1'b0;
            cmp_b <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // Only the first differing bit may set the decision.
            if (!decided) begin
              dec_gt <= cmp_gt;
              dec_lt <= cmp_lt;
            end
            idx   <= idx_nxt;
            cmp_a <= a_reg[idx_nxt];
            cmp_b <= b_reg[idx_nxt];
          end
        end

        default: begin
          cmp_a <= 1'b0;
          cmp_b <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Bench for serial_cmp_ctrl: one early-exit and one full-scan instance run
// side by side. Each instance has its own behavioural 1-bit comparator, and
// a shared fault control forces both comparator responses to 000.
module tb_serial_cmp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic       flt = 1'b0;
  int         fault_edge = 0;

  // Index 1: EARLY_EXIT=1 instance, index 0: EARLY_EXIT=0 instance.
  logic [1:0] cmp_a, cmp_b, cmp_gt, cmp_eq, cmp_lt;
  logic [1:0] busy, done, gt, eq, lt, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign cmp_gt = flt ? 2'b00 : (cmp_a & ~cmp_b);
  assign cmp_eq = flt ? 2'b00 : ~(cmp_a ^ cmp_b);
  assign cmp_lt = flt ? 2'b00 : (~cmp_a & cmp_b);

  serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e1 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .cmp_a(cmp_a[1]), .cmp_b(cmp_b[1]),
    .cmp_gt(cmp_gt[1]), .cmp_eq(cmp_eq[1]), .cmp_lt(cmp_lt[1]),
    .busy(busy[1]), .done(done[1]), .gt(gt[1]), .eq(eq[1]), .lt(lt[1]), .err(err[1])
  );

  serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_e0 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .cmp_a(cmp_a[0]), .cmp_b(cmp_b[0]),
    .cmp_gt(cmp_gt[0]), .cmp_eq(cmp_eq[0]), .cmp_lt(cmp_lt[0]),
    .busy(busy[0]), .done(done[0]), .gt(gt[0]), .eq(eq[0]), .lt(lt[0]), .err(err[0])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Per accepted compare, the model works out the edge count (after the
  // accept edge) at which done must rise, and the final result. The outputs
  // for any cycle then follow from the number of edges since accept.
  logic       m_act [2] = '{1'b0, 1'b0};
  int         m_k   [2] = '{0, 0};
  int         m_end [2] = '{0, 0};
  logic [2:0] m_res [2] = '{3'b000, 3'b000};
  logic       m_abt [2] = '{1'b0, 1'b0};
  logic       m_err [2] = '{1'b0, 1'b0};
  logic [7:0] m_a   [2] = '{8'h00, 8'h00};
  logic [7:0] m_b   [2] = '{8'h00, 8'h00};

  function automatic void plan(input logic [7:0] a, input logic [7:0] b, input int ee,
                               input int fe, output int end_k, output logic [2:0] res,
                               output logic abt);
    int p;
    int nat;
    p = -1;
    for (int i = 7; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        p = i;
        break;
      end
    end
    nat = (ee == 1 && p >= 0) ? 8 - p : 8;
    if (fe > 0 && fe <= nat) begin
      end_k = fe;
      abt   = 1'b1;
      res   = 3'b000;
    end else begin
      end_k = nat;
      abt   = 1'b0;
      res   = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int e = 0; e < 2; e++) begin
      if (rst) begin
        m_act[e] = 1'b0;
        m_k[e]   = 0;
        m_end[e] = 0;
        m_res[e] = 3'b000;
        m_abt[e] = 1'b0;
        m_err[e] = 1'b0;
      end else if (!(m_act[e] && m_k[e] < m_end[e]) && start) begin
        m_act[e] = 1'b1;
        m_k[e]   = 0;
        m_a[e]   = a_in;
        m_b[e]   = b_in;
        plan(a_in, b_in, e, fault_edge, m_end[e], m_res[e], m_abt[e]);
      end else if (m_act[e] && m_k[e] < 1000) begin
        m_k[e] = m_k[e] + 1;
        if (m_k[e] == m_end[e] && m_abt[e]) m_err[e] = 1'b1;
      end
    end
  end

  // Packed expectation: {busy, done, gt, eq, lt, err, cmp_a, cmp_b}.
  function automatic logic [7:0] model_vec(input int e);
    logic       bsy;
    logic       dn;
    logic [2:0] r;
    bsy = m_act[e] && (m_k[e] < m_end[e]);
    dn  = m_act[e] && (m_k[e] == m_end[e]);
    r   = (m_act[e] && m_k[e] >= m_end[e]) ? m_res[e] : 3'b000;
    return {bsy, dn, r, m_err[e], bsy ? m_a[e][7 - m_k[e]] : 1'b0,
            bsy ? m_b[e][7 - m_k[e]] : 1'b0};
  endfunction

  function automatic logic [7:0] dut_vec(input int e);
    return {busy[e], done[e], gt[e], eq[e], lt[e], err[e], cmp_a[e], cmp_b[e]};
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("cycle_ee0", {24'h0, dut_vec(0)}, {24'h0, model_vec(0)});
    check("cycle_ee1", {24'h0, dut_vec(1)}, {24'h0, model_vec(1)});
  end

  // ---------------- directed stimulus ----------------
  int         lat [2];
  logic [7:0] sa  [2];
  logic [7:0] sb  [2];

  // Launch one compare on both instances and wait (bounded) for both dones.
  // fe>0 forces a 000 response sampled on edge E_fe.
  task automatic do_cmp(input logic [7:0] a, input logic [7:0] b, input int fe);
    @(posedge clk); #2;
    a_in = a; b_in = b; fault_edge = fe; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int e = 0; e < 2; e++) begin
      lat[e] = -1;
      sa[e]  = 8'h00;
      sb[e]  = 8'h00;
    end
    for (int k = 0; k < 20; k++) begin
      flt = (fe > 0 && k == fe - 1);
      @(negedge clk);
      for (int e = 0; e < 2; e++) begin
        if (busy[e]) begin
          sa[e] = {sa[e][6:0], cmp_a[e]};
          sb[e] = {sb[e][6:0], cmp_b[e]};
        end
      end
      @(posedge clk); #2;
      for (int e = 0; e < 2; e++)
        if (done[e] && lat[e] < 0) lat[e] = k + 1;
      if (lat[0] >= 0 && lat[1] >= 0) break;
    end
    flt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_ee1", {24'h0, dut_vec(1)}, 32'h0);
    check("reset_ee0", {24'h0, dut_vec(0)}, 32'h0);

    // 1: equal operands scan all bits on both instances.
    do_cmp(8'hA5, 8'hA5, 0);
    check("t1_lat_ee1", lat[1], 8);
    check("t1_lat_ee0", lat[0], 8);
    check("t1_res_ee1", {29'h0, gt[1], eq[1], lt[1]}, 3'b010);
    check("t1_res_ee0", {29'h0, gt[0], eq[0], lt[0]}, 3'b010);

    // 2: MSB differs, early exit after one bit.
    do_cmp(8'h80, 8'h7F, 0);
    check("t2_lat_ee1", lat[1], 1);
    check("t2_cmpa_ee1", {24'h0, sa[1]}, 8'h01);
    check("t2_cmpb_ee1", {24'h0, sb[1]}, 8'h00);
    check("t2_res_ee1", {29'h0, gt[1], eq[1], lt[1]}, 3'b100);
    check("t2_lat_ee0", lat[0], 8);
    check("t2_res_ee0", {29'h0, gt[0], eq[0], lt[0]}, 3'b100);

    // 3: only the LSB differs.
    do_cmp(8'h12, 8'h13, 0);
    check("t3_lat_ee1", lat[1], 8);
    check("t3_lat_ee0", lat[0], 8);
    check("t3_res_ee1", {29'h0, gt[1], eq[1], lt[1]}, 3'b001);
    check("t3_res_ee0", {29'h0, gt[0], eq[0], lt[0]}, 3'b001);

    // 4: full scan keeps the first decision through later equal bits.
    do_cmp(8'h40, 8'h00, 0);
    check("t4_lat_ee0", lat[0], 8);
    check("t4_cmpa_ee0", {24'h0, sa[0]}, 8'h40);
    check("t4_res_ee0", {29'h0, gt[0], eq[0], lt[0]}, 3'b100);
    check("t4_lat_ee1", lat[1], 2);

    // 5: start during RUN is ignored; reset mid-scan clears everything.
    @(posedge clk); #2;
    a_in = 8'h33; b_in = 8'h33; fault_edge = 0; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(posedge clk); #2;
    check("t5_busy_before_rst", {30'h0, busy}, 2'b11);
    rst = 1'b1;
    #1;
    check("t5_rst_ee1", {24'h0, dut_vec(1)}, 32'h0);
    check("t5_rst_ee0", {24'h0, dut_vec(0)}, 32'h0);
    @(posedge clk); #2 rst = 1'b0;
    do_cmp(8'h01, 8'h02, 0);
    check("t5_lat_ee1", lat[1], 7);
    check("t5_lat_ee0", lat[0], 8);
    check("t5_res_ee1", {29'h0, gt[1], eq[1], lt[1]}, 3'b001);
    check("t5_res_ee0", {29'h0, gt[0], eq[0], lt[0]}, 3'b001);

    // 6: malformed response at E2 aborts; err is sticky over a clean compare.
    do_cmp(8'h5A, 8'h5A, 2);
    check("t6_lat_ee1", lat[1], 2);
    check("t6_lat_ee0", lat[0], 2);
    check("t6_res", {26'h0, gt, eq, lt}, 6'b000000);
    check("t6_err", {30'h0, err}, 2'b11);
    do_cmp(8'h03, 8'h01, 0);
    check("t6b_lat_ee1", lat[1], 7);
    check("t6b_res_ee1", {29'h0, gt[1], eq[1], lt[1]}, 3'b100);
    check("t6b_res_ee0", {29'h0, gt[0], eq[0], lt[0]}, 3'b100);
    check("t6b_err", {30'h0, err}, 2'b11);

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
